// File: rtl/dadda_final_adder_seq.sv
// Final carry-propagate adder of the Dadda multiplier: adds the two reduced rows
// CHUNK bits per cycle through a full-adder ripple chain, carry registered between chunks.
`timescale 1ns/1ps

module dadda_final_adder_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] row_a,
    input  logic [WIDTH-1:0] row_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx;
    logic               last;
    logic [CHUNK-1:0]   a_ch, b_ch, ch_sum;
    logic [CHUNK:0]     rc;

    assign last = (idx == IDX_W'(NCH - 1));
    assign a_ch = a_q[idx*CHUNK +: CHUNK];
    assign b_ch = b_q[idx*CHUNK +: CHUNK];
    assign rc[0] = carry_q;

    // One full adder per bit of the chunk: (a, b, c_in) -> (sum, carry).
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign ch_sum[i]  = a_ch[i] ^ b_ch[i] ^ rc[i];
        assign rc[i + 1]  = (a_ch[i] & b_ch[i]) | (rc[i] & (a_ch[i] ^ b_ch[i]));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: the latched operand rows carry no reset; they are only read in ADD,
    // which is always preceded by a load, so resetting them buys nothing.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a_q <= row_a;
            b_q <= row_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            carry_q   <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    idx       <= '0;
                    carry_q   <= 1'b0;
                    sum       <= '0;
                    carry_out <= 1'b0;
                end
                ADD: begin
                    sum[idx*CHUNK +: CHUNK] <= ch_sum;
                    carry_q                 <= rc[CHUNK];
                    if (last) begin
                        idx       <= '0;
                        carry_out <= rc[CHUNK];
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ADD;
            ADD:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake flags depend on state alone, so out_ready never reaches in_ready.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

endmodule

// File: tb/tb_dadda_final_adder_seq.sv
// Bench for dadda_final_adder_seq: directed handshake/reset cases at CHUNK=4 plus
// scoreboarded random traffic on CHUNK = 1, 4, 8 and 16 instances.
`timescale 1ns/1ps

module tb_dadda_final_adder_seq;

    localparam int W    = 16;
    localparam int NOPS = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int rand_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Directed-test DUT (default CHUNK=4).
    logic         rst_n, in_valid, in_ready, out_valid, out_ready, carry_out;
    logic [W-1:0] row_a, row_b, sum;
    logic [W:0]   sb[$];
    logic [W:0]   last_exp;

    dadda_final_adder_seq #(.WIDTH(W), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .row_a(row_a), .row_b(row_b), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out)
    );

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        logic acc = 1'b0;
        @(negedge clk);
        row_a = a; row_b = b; in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            if (in_ready) begin acc = 1'b1; break; end
            @(negedge clk);
        end
        check("accept", 32'(acc), 1);
        sb.push_back({1'b0, a} + {1'b0, b});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        row_a = $urandom; row_b = $urandom;
    endtask

    task automatic wait_result();
        int lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check("add_hi_zero", 32'(sum[W-1:4]), 0);
            if (out_valid) begin lat = k; break; end
        end
        check("latency", lat, 4);
        check("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            last_exp = sb.pop_front();
            check("result", {carry_out, sum}, last_exp);
        end
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ov_drop", 32'(out_valid), 0);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; row_a = '0; row_b = '0;

        // Reset with random inputs toggling.
        repeat (5) begin
            @(negedge clk);
            row_a = $urandom; row_b = $urandom;
            in_valid = 1'($urandom); out_ready = 1'($urandom);
        end
        #1;
        check("rst_ov", 32'(out_valid), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_co", 32'(carry_out), 0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 1);

        // Carry across chunk boundary, then wrap-around cases.
        send(16'h00FF, 16'h0001); wait_result(); take();
        check("c1_val", 32'(last_exp), 32'h0100);
        send(16'hFFFF, 16'h0001); wait_result(); take();
        check("wrap1_val", 32'(last_exp), 32'h10000);
        send(16'hFFFF, 16'hFFFF); wait_result(); take();
        check("wrap2_val", 32'(last_exp), 32'h1FFFE);

        // Backpressure: result held with a new pair waiting on in_valid.
        send(16'h0F0F, 16'h00F1); wait_result();
        @(negedge clk);
        row_a = 16'h1111; row_b = 16'h2222; in_valid = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("bp_ov", 32'(out_valid), 1);
            check("bp_hold", {carry_out, sum}, 32'h1000);
            check("bp_in_ready", 32'(in_ready), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_ready", 32'(in_ready), 1);
        check("bp_idle_ov", 32'(out_valid), 0);
        sb.push_back(17'h03333);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(); take();

        // Reset two edges after acceptance aborts the operation.
        send(16'hAAAA, 16'h5555);
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_ov", 32'(out_valid), 0);
        check("abort_sum", 32'(sum), 0);
        check("abort_co", 32'(carry_out), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_ov", 32'(out_valid), 0);
        send(16'h1234, 16'h4321); wait_result(); take();
        check("post_abort_val", 32'(last_exp), 32'h5555);

        for (int t = 0; t < 60000 && rand_done < 4; t++) @(posedge clk);
        check("rand_done", rand_done, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Random traffic on one instance per chunk size, each with its own scoreboard.
    for (genvar g = 0; g < 4; g++) begin : g_rand
        localparam int CH = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 16;

        logic         r_rst_n, iv, ir, ov, orr, co;
        logic [W-1:0] ra, rb, s;
        logic [W:0]   q[$];
        int           seen;

        dadda_final_adder_seq #(.WIDTH(W), .CHUNK(CH)) dut_r (
            .clk(clk), .rst_n(r_rst_n), .in_valid(iv), .in_ready(ir),
            .row_a(ra), .row_b(rb), .out_valid(ov), .out_ready(orr),
            .sum(s), .carry_out(co)
        );

        initial begin
            r_rst_n = 1'b0; iv = 1'b0; ra = '0; rb = '0;
            repeat (3) @(negedge clk);
            r_rst_n = 1'b1;
            for (int n = 0; n < NOPS; n++) begin
                logic acc = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                ra = $urandom; rb = $urandom; iv = 1'b1;
                for (int t = 0; t < 200; t++) begin
                    if (ir) begin acc = 1'b1; break; end
                    @(negedge clk);
                end
                if (!acc) begin
                    check($sformatf("rand_accept_c%0d", CH), 32'(acc), 1);
                    break;
                end
                q.push_back({1'b0, ra} + {1'b0, rb});
                @(negedge clk);
                iv = 1'b0; ra = $urandom; rb = $urandom;
            end
        end

        initial begin
            logic pending = 1'b0;
            orr = 1'b0; seen = 0;
            @(posedge r_rst_n);
            for (int t = 0; t < 60000 && seen < NOPS; t++) begin
                @(negedge clk);
                orr = 1'b0;
                if (ov) begin
                    if (!pending) begin
                        pending = 1'b1;
                        seen++;
                        check($sformatf("rand_sb_c%0d", CH), 32'(q.size() > 0), 1);
                        if (q.size() > 0)
                            check($sformatf("rand_c%0d", CH), {co, s}, q.pop_front());
                    end
                    orr = ($urandom_range(0, 3) != 0);
                    if (orr) pending = 1'b0;
                end
            end
            @(negedge clk);
            orr = 1'b0;
            check($sformatf("rand_count_c%0d", CH), seen, NOPS);
            rand_done++;
        end
    end

endmodule
